// File: rtl/uart_tx_arbiter.sv
// Arbitrates four byte requesters onto a single UART transmitter, one frame per grant.
// Build macro UART_ARB_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
//
// state       | meaning
// S_IDLE      | waiting for a request while the transmitter is quiet
// S_WAIT_ACT  | byte launched, waiting for the transmitter to go busy
// S_WAIT_DONE | frame in flight, waiting for the frame-complete pulse
// S_GAP       | enforced idle spacing before the next grant
module uart_tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic [3:0]  i_Req_DV,
    input  logic [31:0] i_Req_Byte,
    output logic [3:0]  o_Req_Ack,
    output logic [3:0]  o_Req_Done,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Busy,
    output logic [1:0]  o_Grant_Idx
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACT  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     r_State;
    logic [7:0] r_Gap_Cnt;
    logic [1:0] w_Winner;
    logic       w_Grant;

    // The transmitter has no reset, so a still-running frame must also block a grant.
    assign w_Grant = (r_State == S_IDLE) && (|i_Req_DV) && !i_Tx_Active && !i_Tx_Done;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        w_Winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i_Req_DV[i]) w_Winner = 2'(i);
        end
    end
`else
    logic [1:0] r_Last;
    logic       w_Found;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_Last <= 2'd3;
        end else if (w_Grant) begin
            r_Last <= w_Winner;
        end
    end

    // Search starts one past the last winner; 2-bit arithmetic gives the wrap-around.
    always_comb begin
        w_Winner = r_Last;
        w_Found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_Found && i_Req_DV[r_Last + 2'(k)]) begin
                w_Winner = r_Last + 2'(k);
                w_Found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_State     <= S_IDLE;
            r_Gap_Cnt   <= 8'd0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Req_Ack   <= 4'b0000;
            o_Req_Done  <= 4'b0000;
            o_Grant_Idx <= 2'd0;
        end else begin
            o_Tx_DV    <= 1'b0;
            o_Req_Ack  <= 4'b0000;
            o_Req_Done <= 4'b0000;
            case (r_State)
                S_IDLE: begin
                    if (w_Grant) begin
                        o_Tx_DV     <= 1'b1;
                        o_Tx_Byte   <= i_Req_Byte[{w_Winner, 3'b000} +: 8];
                        o_Req_Ack   <= 4'b0001 << w_Winner;
                        o_Grant_Idx <= w_Winner;
                        r_State     <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (i_Tx_Active) r_State <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        o_Req_Done <= 4'b0001 << o_Grant_Idx;
                        r_Gap_Cnt  <= 8'd0;
                        r_State    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_Gap_Cnt == GAP_LAST) begin
                        r_State <= S_IDLE;
                    end else begin
                        r_Gap_Cnt <= r_Gap_Cnt + 8'd1;
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    assign o_Busy = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter paired with a behavioural UART transmitter (CLKS_PER_BIT=2).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int GAP          = 3;
    localparam int CLKS_PER_BIT = 2;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } grant_t;

    logic        i_Clock = 1'b0;
    logic        i_Rst_n;
    logic [3:0]  i_Req_DV;
    logic [31:0] i_Req_Byte;
    logic [3:0]  o_Req_Ack;
    logic [3:0]  o_Req_Done;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        o_Busy;
    logic [1:0]  o_Grant_Idx;
    logic        done_inj;
    logic        tx_done_line;

    logic        tx_active = 1'b0;
    logic        tx_done   = 1'b0;
    logic        tx_serial = 1'b1;
    int          tx_cnt    = 0;
    int          tx_bit    = 0;
    logic [9:0]  tx_shift  = 10'h3FF;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    grant_t exp_q[$];

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    assign tx_done_line = tx_done | done_inj;

    uart_tx_arbiter #(.GAP_CYCLES(GAP)) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Req_DV    (i_Req_DV),
        .i_Req_Byte  (i_Req_Byte),
        .o_Req_Ack   (o_Req_Ack),
        .o_Req_Done  (o_Req_Done),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done_line),
        .o_Busy      (o_Busy),
        .o_Grant_Idx (o_Grant_Idx)
    );

    // Transmitter model: no reset, start bit + 8 data LSB-first + stop, one-cycle done.
    always @(posedge i_Clock) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            if (o_Tx_DV) begin
                tx_active <= 1'b1;
                tx_shift  <= {1'b1, o_Tx_Byte, 1'b0};
                tx_serial <= 1'b0;
                tx_cnt    <= 0;
                tx_bit    <= 0;
            end
        end else if (tx_cnt == CLKS_PER_BIT - 1) begin
            tx_cnt <= 0;
            if (tx_bit == 9) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                tx_serial <= 1'b1;
            end else begin
                tx_bit    <= tx_bit + 1;
                tx_serial <= tx_shift[tx_bit + 1];
            end
        end else begin
            tx_cnt <= tx_cnt + 1;
        end
    end

    task automatic wait_dv(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge i_Clock);
            if (o_Tx_DV === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        bit quiet;
        quiet = 1'b0;
        repeat (2) @(negedge i_Clock);
        for (int n = 0; n < 100; n++) begin
            if (!tx_active && o_Busy !== 1'b1) begin
                quiet = 1'b1;
                break;
            end
            @(negedge i_Clock);
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL reset_wait_idle: idle=%0b required 1", quiet);
        end
        i_Rst_n = 1'b0;
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_Req_DV   = 4'hF;
        i_Req_Byte = 32'h44332211;
        i_Rst_n    = 1'b0;
        repeat (3) @(negedge i_Clock);
        n_cmp++; if (o_Tx_DV !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv: got %0b required 0", o_Tx_DV); end
        n_cmp++; if (o_Tx_Byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %02h required 00", o_Tx_Byte); end
        n_cmp++; if (o_Req_Ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %04b required 0000", o_Req_Ack); end
        n_cmp++; if (o_Req_Done !== 4'b0000) begin n_bad++; $display("FAIL reset_done: got %04b required 0000", o_Req_Done); end
        n_cmp++; if (o_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b required 0", o_Busy); end
        n_cmp++; if (o_Grant_Idx !== 2'd0) begin n_bad++; $display("FAIL reset_grant_idx: got %0d required 0", o_Grant_Idx); end
        i_Req_DV = 4'h0;
        i_Rst_n  = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        grant_t g;
        logic [9:0] frame;
        int dones, dvs;
        apply_reset();
        i_Req_Byte = 32'h000000A5;
        i_Req_DV   = 4'b0001;
        exp_q.push_back('{2'd0, 8'hA5});
        wait_dv(10, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL single_launch: no o_Tx_DV within 10 cycles");
            i_Req_DV = 4'b0000;
            return;
        end
        g = exp_q.pop_front();
        n_cmp++; if (o_Tx_Byte !== g.data) begin n_bad++; $display("FAIL single_byte: got %02h required %02h", o_Tx_Byte, g.data); end
        n_cmp++; if (o_Req_Ack !== (4'b0001 << g.idx)) begin n_bad++; $display("FAIL single_ack: got %04b required %04b", o_Req_Ack, 4'b0001 << g.idx); end
        n_cmp++; if (o_Grant_Idx !== g.idx) begin n_bad++; $display("FAIL single_grant_idx: got %0d required %0d", o_Grant_Idx, g.idx); end
        n_cmp++; if (o_Busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0b required 1", o_Busy); end
        i_Req_DV = 4'b0000;
        frame = {1'b1, g.data, 1'b0};
        @(negedge i_Clock);
        n_cmp++; if (o_Tx_DV !== 1'b0) begin n_bad++; $display("FAIL single_dv_width: got %0b required 0", o_Tx_DV); end
        n_cmp++; if (o_Req_Ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_width: got %04b required 0000", o_Req_Ack); end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (CLKS_PER_BIT) @(negedge i_Clock);
            n_cmp++;
            if (tx_serial !== frame[k]) begin
                n_bad++; $display("FAIL single_serial_bit%0d: got %0b required %0b", k, tx_serial, frame[k]);
            end
        end
        dones = 0;
        dvs   = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge i_Clock);
            if (o_Req_Done === 4'b0001) dones++;
            else if (o_Req_Done !== 4'b0000) dones += 100;
            if (o_Tx_DV === 1'b1) dvs++;
        end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL single_done_count: got %0d required 1", dones); end
        n_cmp++; if (dvs != 0) begin n_bad++; $display("FAIL single_extra_dv: got %0d required 0", dvs); end
    endtask

    task automatic run_grants(input string name);
        bit ok;
        grant_t g;
        int n, last_cyc;
        n = exp_q.size();
        last_cyc = -1;
        for (int i = 0; i < n; i++) begin
            wait_dv(FRAME + GAP + 40, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL %s_timeout: grant %0d never launched", name, i);
                break;
            end
            g = exp_q.pop_front();
            n_cmp++; if (o_Grant_Idx !== g.idx) begin n_bad++; $display("FAIL %s_idx%0d: got %0d required %0d", name, i, o_Grant_Idx, g.idx); end
            n_cmp++; if (o_Tx_Byte !== g.data) begin n_bad++; $display("FAIL %s_byte%0d: got %02h required %02h", name, i, o_Tx_Byte, g.data); end
            n_cmp++; if (o_Req_Ack !== (4'b0001 << g.idx)) begin n_bad++; $display("FAIL %s_ack%0d: got %04b required %04b", name, i, o_Req_Ack, 4'b0001 << g.idx); end
            if (last_cyc >= 0) begin
                n_cmp++;
                if (cyc - last_cyc != FRAME + GAP + 3) begin
                    n_bad++; $display("FAIL %s_spacing%0d: got %0d cycles required %0d", name, i, cyc - last_cyc, FRAME + GAP + 3);
                end
            end
            last_cyc = cyc;
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        i_Req_Byte = 32'h44332211;
        i_Req_DV   = 4'hF;
`ifdef UART_ARB_FIXED_PRIO_EN
        repeat (3) exp_q.push_back('{2'd0, 8'h11});
`else
        exp_q.push_back('{2'd0, 8'h11});
        exp_q.push_back('{2'd1, 8'h22});
        exp_q.push_back('{2'd2, 8'h33});
        exp_q.push_back('{2'd3, 8'h44});
        exp_q.push_back('{2'd0, 8'h11});
`endif
        run_grants("rr");
        i_Req_DV = 4'h0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_Req_Byte = 32'hC3000000;
        i_Req_DV   = 4'b1000;
        repeat (3) exp_q.push_back('{2'd3, 8'hC3});
        run_grants("b2b");
        i_Req_DV = 4'h0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok, saw_done, idle_at_grant;
        grant_t g;
        int dones;
        apply_reset();
        i_Req_Byte = 32'h005A00A5;
        i_Req_DV   = 4'b0001;
        wait_dv(10, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL midrst_launch: no o_Tx_DV within 10 cycles");
            i_Req_DV = 4'b0000;
            return;
        end
        i_Req_DV = 4'b0100;
        exp_q.push_back('{2'd2, 8'h5A});
        repeat (11) @(negedge i_Clock);
        n_cmp++; if (tx_active !== 1'b1 || tx_bit != 5) begin n_bad++; $display("FAIL midrst_position: active=%0b bit=%0d required 1/5", tx_active, tx_bit); end
        i_Rst_n = 1'b0;
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        n_cmp++; if (o_Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b required 0", o_Busy); end
        ok = 1'b0;
        saw_done = 1'b0;
        idle_at_grant = 1'b0;
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            if (o_Req_Done !== 4'b0000) dones++;
            if (o_Tx_DV === 1'b1) begin
                ok = 1'b1;
                idle_at_grant = !tx_active;
                break;
            end
            if (tx_done) saw_done = 1'b1;
            @(negedge i_Clock);
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL midrst_done: got %0d pulses required 0", dones); end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_regrant: no o_Tx_DV within 60 cycles"); end
        n_cmp++; if (!saw_done) begin n_bad++; $display("FAIL midrst_early_grant: tx_done seen=%0b required 1", saw_done); end
        n_cmp++; if (!idle_at_grant) begin n_bad++; $display("FAIL midrst_tx_busy: tx idle at grant=%0b required 1", idle_at_grant); end
        if (ok) begin
            g = exp_q.pop_front();
            n_cmp++; if (o_Grant_Idx !== g.idx) begin n_bad++; $display("FAIL midrst_idx: got %0d required %0d", o_Grant_Idx, g.idx); end
            n_cmp++; if (o_Tx_Byte !== g.data) begin n_bad++; $display("FAIL midrst_byte: got %02h required %02h", o_Tx_Byte, g.data); end
        end
        i_Req_DV = 4'b0000;
    endtask

    task automatic test_withdraw_spurious();
        bit ok, got_done;
        grant_t g;
        int acks2, extra, dvs;
        apply_reset();
        i_Req_Byte = 32'h0077003C;
        i_Req_DV   = 4'b0001;
        exp_q.push_back('{2'd0, 8'h3C});
        wait_dv(10, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL wd_launch: no o_Tx_DV within 10 cycles");
            i_Req_DV = 4'b0000;
            return;
        end
        g = exp_q.pop_front();
        n_cmp++; if (o_Req_Ack !== (4'b0001 << g.idx)) begin n_bad++; $display("FAIL wd_ack: got %04b required %04b", o_Req_Ack, 4'b0001 << g.idx); end
        i_Req_DV = 4'b0100;
        repeat (5) @(negedge i_Clock);
        i_Req_DV = 4'b0000;
        acks2 = 0;
        got_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_Clock);
            if (o_Req_Ack[2] === 1'b1) acks2++;
            if (o_Req_Done !== 4'b0000) begin
                got_done = 1'b1;
                break;
            end
        end
        n_cmp++; if (!got_done || o_Req_Done !== 4'b0001) begin n_bad++; $display("FAIL wd_done: got %04b required 0001", o_Req_Done); end
        n_cmp++; if (o_Busy !== 1'b1) begin n_bad++; $display("FAIL wd_gap_busy: got %0b required 1", o_Busy); end
        done_inj = 1'b1;
        @(negedge i_Clock);
        done_inj = 1'b0;
        extra = 0;
        dvs = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_Clock);
            if (o_Req_Done !== 4'b0000) extra++;
            if (o_Req_Ack[2] === 1'b1) acks2++;
            if (o_Tx_DV === 1'b1) dvs++;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL wd_spurious_done: got %0d pulses required 0", extra); end
        n_cmp++; if (acks2 != 0) begin n_bad++; $display("FAIL wd_withdrawn_ack: got %0d acks required 0", acks2); end
        n_cmp++; if (dvs != 0) begin n_bad++; $display("FAIL wd_extra_dv: got %0d required 0", dvs); end
        n_cmp++; if (o_Busy !== 1'b0) begin n_bad++; $display("FAIL wd_idle: got busy=%0b required 0", o_Busy); end
    endtask

    initial begin
        i_Rst_n    = 1'b0;
        i_Req_DV   = 4'h0;
        i_Req_Byte = 32'h0;
        done_inj   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_frame();
        test_withdraw_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, idle cycles inserted after each completed frame before the next grant; legal range 1..255.
REQ-002 Port i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 Port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port i_Req_DV  input  4  per-requester byte-valid; bit n belongs to requester n.
REQ-005 Port i_Req_Byte  input  32  requester n's byte on bits [8n+7:8n].
REQ-006 Port o_Req_Ack  output  4  one-hot, one-cycle pulse: requester n's byte accepted.
REQ-007 Port o_Req_Done  output  4  one-hot, one-cycle pulse: requester n's frame fully transmitted.
REQ-008 Port o_Tx_DV  output  1  one-cycle launch strobe to the UART transmitter.
REQ-009 Port o_Tx_Byte  output  8  byte to the transmitter; stable from launch until the next grant.
REQ-010 Port i_Tx_Active  input  1  transmitter busy flag.
REQ-011 Port i_Tx_Done  input  1  transmitter one-cycle frame-complete pulse.
REQ-012 Port o_Busy  output  1  high in every state except S_IDLE.
REQ-013 Port o_Grant_Idx  output  2  index of the most recent grant.

Function
REQ-014 State machine SHALL have four states: S_IDLE, S_WAIT_ACT, S_WAIT_DONE, S_GAP.
REQ-015 Grant condition in S_IDLE SHALL be: any i_Req_DV bit high AND i_Tx_Active=0 AND i_Tx_Done=0.
REQ-016 On the grant edge the block SHALL register o_Tx_DV=1, o_Tx_Byte=winner byte, o_Req_Ack=onehot(winner), o_Grant_Idx=winner, and move to S_WAIT_ACT.
REQ-017 o_Tx_DV and o_Req_Ack SHALL return to 0 on the following edge, giving exactly one-cycle pulses.
REQ-018 Requesters SHALL hold i_Req_DV and the byte until ack; a bit dropped before ack is withdrawn without error.
REQ-019 Round-robin arbitration SHALL search from (r_Last+1) mod 4 upward with wrap-around; r_Last updates to the winner on the grant edge.
REQ-020 S_WAIT_ACT SHALL move to S_WAIT_DONE on the first cycle with i_Tx_Active=1.
REQ-021 S_WAIT_DONE SHALL, on i_Tx_Done=1, register o_Req_Done=onehot(o_Grant_Idx) for one cycle and enter S_GAP with the gap counter cleared.
REQ-022 S_GAP SHALL count GAP_CYCLES cycles (8-bit counter) and then return to S_IDLE.
REQ-023 Grant-to-next-grant minimum SHALL be frame length + GAP_CYCLES + 3 cycles.
REQ-024 i_Req_DV changes outside S_IDLE SHALL have no effect; requests are only evaluated in S_IDLE.
REQ-025 An i_Tx_Done pulse outside S_WAIT_DONE SHALL be ignored.
REQ-026 Simultaneous requests SHALL yield exactly one grant per frame; no requester SHALL wait more than 3 frames while continuously requesting.

Reset
REQ-027 i_Rst_n=0 at a clock edge SHALL force S_IDLE, r_Last=3, gap counter=0, and every output to 0 (o_Tx_Byte=8'h00, o_Grant_Idx=0).
REQ-028 Reset mid-frame SHALL abort without o_Req_Done.
REQ-029 After reset mid-frame, the REQ-015 guard SHALL hold off new grants until the transmitter is idle, since the transmitter itself has no reset.

Configuration
REQ-030 With macro UART_ARB_FIXED_PRIO_EN defined, the winner SHALL always be the lowest-index active requester, and r_Last SHALL be unused.
REQ-031 With UART_ARB_FIXED_PRIO_EN undefined, the REQ-019 round-robin SHALL apply.

Verification
REQ-032 Bench SHALL pair the block with a UART transmitter at CLKS_PER_BIT=2 and cover:
- Single request: i_Req_DV=4'b0001, byte0=8'hA5 -> one o_Tx_DV pulse with o_Tx_Byte=8'hA5, o_Req_Ack=4'b0001; serial line shows 0,1,0,1,0,0,1,0,1,1; o_Req_Done=4'b0001 once.
- All four requesting continuously, bytes 8'h11/8'h22/8'h33/8'h44 -> round-robin grant order 0,1,2,3,0; fixed-priority build -> 0,0,0.
- Back-to-back, GAP_CYCLES=3 -> rising edges of o_Tx_DV exactly 20+3+3=26 cycles apart.
- i_Rst_n low for 1 cycle during data bit 4 of a frame -> no o_Req_Done; next o_Tx_DV only after i_Tx_Active falls and i_Tx_Done has pulsed.
- Request 2 withdrawn before S_IDLE -> no ack on bit 2; spurious i_Tx_Done in S_GAP -> no o_Req_Done.
